// File: rtl/cx_dma_req_sched.sv
// cx_dma_req_sched
//   Two-port DMA stream sequencer. Port 0 is the READ stream and port 1 is
//   the WRITE stream. Each port accepts one packet (base, inclusive end, size,
//   byte stride, id). It expands the packet into strided beats and
//   round-robin arbitrates them onto one registered memory request channel.
//   Each port is limited to MAX_OUTSTANDING unresponded beats. A one-cycle
//   done pulse is raised once every response for the packet has returned.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pkt_valid/pkt_ready[1:0]    per-port packet handshake (ready = port idle)
//   pkt_base/end/size/stride/id per-port packet fields
//   req_valid/req_ready         memory request handshake
//   req_addr/size/rw/id/last    registered beat fields (rw = owning port)
//   rsp_valid[1:0]              one returned response per port per cycle
//   done_valid/done_id[1:0]     per-port completion pulse and packet tag
module cx_dma_req_sched #(
  parameter int unsigned MEM_ADDR_WIDTH  = 32,
  parameter int unsigned MEM_ID_WIDTH    = 12,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          pkt_valid,
  output logic [1:0]                          pkt_ready,
  input  logic [1:0][MEM_ADDR_WIDTH-1:0]      pkt_base,
  input  logic [1:0][MEM_ADDR_WIDTH-1:0]      pkt_end,
  input  logic [1:0][2:0]                     pkt_size,
  input  logic [1:0][31:0]                    pkt_stride,
  input  logic [1:0][MEM_ID_WIDTH-1:0]        pkt_id,
  output logic                                req_valid,
  input  logic                                req_ready,
  output logic [MEM_ADDR_WIDTH-1:0]           req_addr,
  output logic [2:0]                          req_size,
  output logic                                req_rw,
  output logic [MEM_ID_WIDTH-1:0]             req_id,
  output logic                                req_last,
  input  logic [1:0]                          rsp_valid,
  output logic [1:0]                          done_valid,
  output logic [1:0][MEM_ID_WIDTH-1:0]        done_id
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t state_q [2];
  state_t state_d [2];

  logic [1:0][MEM_ADDR_WIDTH-1:0] cur_addr;
  logic [1:0][MEM_ADDR_WIDTH-1:0] end_q;
  logic [1:0][31:0]               stride_q;
  logic [1:0][2:0]                size_q;
  logic [1:0][MEM_ID_WIDTH-1:0]   id_q;
  logic [1:0][CW-1:0]             outs_q;
  logic [1:0][MEM_ADDR_WIDTH:0]   nxt;
  logic [1:0]                     want;
  logic [1:0]                     last;
  logic [1:0]                     issue;
  logic                           load;
  logic                           any_want;
  logic                           gnt;
  logic                           rr_q;

  // Beat request, last-beat detection and grant.
  // The extra top bit of nxt catches address wrap-around, which also ends
  // the packet, so a base beyond end still yields exactly one beat.
  always_comb begin
    want  = '0;
    last  = '0;
    nxt   = '0;
    issue = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      want[p] = (state_q[p] == BUSY) && (outs_q[p] < MAX_CNT);
      nxt[p]  = {1'b0, cur_addr[p]} + (MEM_ADDR_WIDTH+1)'(stride_q[p]);
      last[p] = (stride_q[p] == '0) || nxt[p][MEM_ADDR_WIDTH] ||
                (nxt[p][MEM_ADDR_WIDTH-1:0] > end_q[p]);
    end
    load     = !req_valid || req_ready;
    any_want = |want;
    // rr_q == 1 favours port 1 when both ports request.
    gnt      = want[1] && (!want[0] || rr_q);
    if (load && any_want) issue[gnt] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned p = 0; p < 2; p++) state_q[p] <= IDLE;
    end else begin
      for (int unsigned p = 0; p < 2; p++) state_q[p] <= state_d[p];
    end
  end

  // Next-state logic.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      unique case (state_q[p])
        IDLE:    if (pkt_valid[p])            state_d[p] = BUSY;
        BUSY:    if (issue[p] && last[p])     state_d[p] = DRAIN;
        DRAIN:   if (outs_q[p] == '0)         state_d[p] = IDLE;
        default:                              state_d[p] = IDLE;
      endcase
    end
  end

  // Port-facing outputs.
  always_comb begin
    pkt_ready  = '0;
    done_valid = '0;
    done_id    = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      pkt_ready[p]  = (state_q[p] == IDLE);
      done_valid[p] = (state_q[p] == DRAIN) && (outs_q[p] == '0);
      if (done_valid[p]) done_id[p] = id_q[p];
    end
  end

  // Packet capture, address stepping, credit counters and request register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr  <= '0;
      end_q     <= '0;
      stride_q  <= '0;
      size_q    <= '0;
      id_q      <= '0;
      outs_q    <= '0;
      rr_q      <= 1'b0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_size  <= '0;
      req_rw    <= 1'b0;
      req_id    <= '0;
      req_last  <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (state_q[p] == IDLE && pkt_valid[p]) begin
          cur_addr[p] <= pkt_base[p];
          end_q[p]    <= pkt_end[p];
          stride_q[p] <= pkt_stride[p];
          size_q[p]   <= pkt_size[p];
          id_q[p]     <= pkt_id[p];
        end else if (issue[p]) begin
          cur_addr[p] <= nxt[p][MEM_ADDR_WIDTH-1:0];
        end
        // A response with nothing outstanding is ignored (floor at zero).
        if (issue[p] && !rsp_valid[p])
          outs_q[p] <= outs_q[p] + 1'b1;
        else if (!issue[p] && rsp_valid[p] && outs_q[p] != '0)
          outs_q[p] <= outs_q[p] - 1'b1;
      end
      if (load) begin
        if (any_want) begin
          req_valid <= 1'b1;
          req_addr  <= cur_addr[gnt];
          req_size  <= size_q[gnt];
          req_rw    <= gnt;
          req_id    <= id_q[gnt];
          req_last  <= last[gnt];
          rr_q      <= ~gnt;
        end else begin
          req_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cx_dma_req_sched.sv
module tb_cx_dma_req_sched;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [1:0]          pkt_valid, pkt_ready, s_pkt_valid, s_pkt_ready;
  logic [1:0][31:0]    pkt_base, pkt_end, pkt_stride;
  logic [1:0][2:0]     pkt_size;
  logic [1:0][11:0]    pkt_id;
  logic                req_valid, req_ready, req_rw, req_last;
  logic [31:0]         req_addr;
  logic [2:0]          req_size;
  logic [11:0]         req_id;
  logic [1:0]          rsp_valid, done_valid;
  logic [1:0][11:0]    done_id;
  logic                s_req_valid, s_req_rw, s_req_last;
  logic [31:0]         s_req_addr;
  logic [2:0]          s_req_size;
  logic [11:0]         s_req_id;
  logic [1:0]          s_rsp_valid, s_done_valid;
  logic [1:0][11:0]    s_done_id;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cx_dma_req_sched dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_base(pkt_base), .pkt_end(pkt_end), .pkt_size(pkt_size),
    .pkt_stride(pkt_stride), .pkt_id(pkt_id),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_rw(req_rw), .req_id(req_id), .req_last(req_last),
    .rsp_valid(rsp_valid), .done_valid(done_valid), .done_id(done_id)
  );

  cx_dma_req_sched #(.MAX_OUTSTANDING(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(s_pkt_valid), .pkt_ready(s_pkt_ready),
    .pkt_base(pkt_base), .pkt_end(pkt_end), .pkt_size(pkt_size),
    .pkt_stride(pkt_stride), .pkt_id(pkt_id),
    .req_valid(s_req_valid), .req_ready(req_ready), .req_addr(s_req_addr),
    .req_size(s_req_size), .req_rw(s_req_rw), .req_id(s_req_id), .req_last(s_req_last),
    .rsp_valid(s_rsp_valid), .done_valid(s_done_valid), .done_id(s_done_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int p, input logic [31:0] b, input logic [31:0] e,
                         input logic [31:0] st, input logic [2:0] sz, input logic [11:0] id);
    pkt_base[p]   = b;
    pkt_end[p]    = e;
    pkt_stride[p] = st;
    pkt_size[p]   = sz;
    pkt_id[p]     = id;
  endtask

  // Single-beat packet: handshake, one beat flagged last, one response, done.
  task automatic one_beat(input int p, input logic [31:0] b, input logic [31:0] e,
                          input logic [31:0] st, input logic [11:0] id, input string tag);
    logic [23:0] exp_id;
    exp_id = 24'(id) << (12 * p);
    set_pkt(p, b, e, st, 3'd2, id);
    chk({tag, " ready"}, 64'(pkt_ready[p]), 64'd1);
    pkt_valid[p] = 1'b1;
    step;
    pkt_valid[p] = 1'b0;
    step;
    chk({tag, " valid"}, 64'(req_valid), 64'd1);
    chk({tag, " addr"}, 64'(req_addr), 64'(b));
    chk({tag, " last"}, 64'(req_last), 64'd1);
    chk({tag, " rw"}, 64'(req_rw), 64'(p));
    step;
    chk({tag, " single beat"}, 64'(req_valid), 64'd0);
    rsp_valid[p] = 1'b1;
    step;
    rsp_valid[p] = 1'b0;
    chk({tag, " done"}, 64'(done_valid), 64'd1 << p);
    chk({tag, " done_id"}, 64'(done_id), 64'(exp_id));
    step;
    chk({tag, " idle"}, 64'(pkt_ready), 64'd3);
  endtask

  int          n;
  logic [31:0] a;
  logic [31:0] exp_a;

  initial begin
    rst_n = 1'b0;
    pkt_valid = '0; s_pkt_valid = '0;
    rsp_valid = '0; s_rsp_valid = '0;
    req_ready = 1'b1;
    pkt_base = '0; pkt_end = '0; pkt_stride = '0; pkt_size = '0; pkt_id = '0;
    #2;
    chk("rst req_valid", 64'(req_valid), 64'd0);
    chk("rst req_addr", 64'(req_addr), 64'd0);
    chk("rst pkt_ready", 64'(pkt_ready), 64'd3);
    chk("rst done_valid", 64'(done_valid), 64'd0);
    chk("rst done_id", 64'(done_id), 64'd0);
    #10 rst_n = 1'b1;
    step;

    // Both ports together: grants alternate starting with port 0.
    set_pkt(0, 32'h2000, 32'h200C, 32'd4, 3'd2, 12'h0A1);
    set_pkt(1, 32'h3000, 32'h300C, 32'd4, 3'd2, 12'h0B2);
    pkt_valid = 2'b11;
    step;
    pkt_valid = 2'b00;
    step;
    for (int i = 0; i < 8; i++) begin
      exp_a = ((i % 2) == 0 ? 32'h2000 : 32'h3000) + 32'(4 * (i / 2));
      chk("rr valid", 64'(req_valid), 64'd1);
      chk("rr addr", 64'(req_addr), 64'(exp_a));
      chk("rr rw", 64'(req_rw), 64'(i % 2));
      chk("rr last", 64'(req_last), 64'(i >= 6));
      step;
    end
    chk("rr drained", 64'(req_valid), 64'd0);
    rsp_valid = 2'b11;
    repeat (4) step;
    rsp_valid = 2'b00;
    chk("rr done both", 64'(done_valid), 64'd3);
    chk("rr done ids", 64'(done_id), 64'h0B2_0A1);
    step;
    chk("rr idle", 64'(pkt_ready), 64'd3);

    // Port 0 three-beat packet, responses three cycles after each beat.
    set_pkt(0, 32'h1000, 32'h1010, 32'd8, 3'd3, 12'h12A);
    chk("p0 ready", 64'(pkt_ready), 64'd3);
    pkt_valid = 2'b01;
    step;
    pkt_valid = 2'b00;
    chk("p0 latency", 64'(req_valid), 64'd0);
    step;
    chk("p0 b0 valid", 64'(req_valid), 64'd1);
    chk("p0 b0 addr", 64'(req_addr), 64'h1000);
    chk("p0 b0 last", 64'(req_last), 64'd0);
    chk("p0 b0 rw", 64'(req_rw), 64'd0);
    chk("p0 b0 id", 64'(req_id), 64'h12A);
    chk("p0 b0 size", 64'(req_size), 64'd3);
    step;
    chk("p0 b1 addr", 64'(req_addr), 64'h1008);
    chk("p0 b1 last", 64'(req_last), 64'd0);
    step;
    chk("p0 b2 addr", 64'(req_addr), 64'h1010);
    chk("p0 b2 last", 64'(req_last), 64'd1);
    step;
    chk("p0 drained", 64'(req_valid), 64'd0);
    chk("p0 busy ready", 64'(pkt_ready), 64'd2);
    rsp_valid = 2'b01;
    step;
    step;
    chk("p0 early done", 64'(done_valid), 64'd0);
    step;
    rsp_valid = 2'b00;
    chk("p0 done", 64'(done_valid), 64'd1);
    chk("p0 done_id", 64'(done_id), 64'h12A);
    step;
    chk("p0 done pulse", 64'(done_valid), 64'd0);
    chk("p0 ready back", 64'(pkt_ready), 64'd3);

    // Credit limit of 2 on the small instance: 2 beats, then one per response.
    set_pkt(0, 32'h5000, 32'h5040, 32'h10, 3'd2, 12'h5A5);
    chk("cr ready", 64'(s_pkt_ready), 64'd3);
    s_pkt_valid = 2'b01;
    step;
    s_pkt_valid = 2'b00;
    n = 0;
    a = '0;
    for (int i = 0; i < 6; i++) begin
      step;
      if (s_req_valid) begin
        n++;
        a = s_req_addr;
      end
    end
    chk("cr beats before rsp", 64'(n), 64'd2);
    chk("cr second addr", 64'(a), 64'h5010);
    s_rsp_valid = 2'b01;
    step;
    s_rsp_valid = 2'b00;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (s_req_valid) begin
        n++;
        a = s_req_addr;
      end
    end
    chk("cr beats after rsp", 64'(n), 64'd1);
    chk("cr third addr", 64'(a), 64'h5020);

    // Back-pressure: request fields hold for 5 cycles, address not advanced.
    req_ready = 1'b0;
    set_pkt(0, 32'h6000, 32'h6030, 32'h10, 3'd1, 12'h3C5);
    pkt_valid = 2'b01;
    step;
    pkt_valid = 2'b00;
    step;
    for (int i = 0; i < 5; i++) begin
      chk("st valid", 64'(req_valid), 64'd1);
      chk("st addr", 64'(req_addr), 64'h6000);
      chk("st id", 64'(req_id), 64'h3C5);
      chk("st last", 64'(req_last), 64'd0);
      if (i < 4) step;
    end
    req_ready = 1'b1;
    step;
    chk("st b1 addr", 64'(req_addr), 64'h6010);
    step;
    chk("st b2 addr", 64'(req_addr), 64'h6020);
    step;
    chk("st b3 addr", 64'(req_addr), 64'h6030);
    chk("st b3 last", 64'(req_last), 64'd1);
    step;
    chk("st drained", 64'(req_valid), 64'd0);
    rsp_valid = 2'b01;
    repeat (4) step;
    rsp_valid = 2'b00;
    chk("st done", 64'(done_valid), 64'd1);
    step;

    // Single-beat boundary packets.
    one_beat(1, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd16, 12'h0F1, "wrap");
    one_beat(0, 32'h0000_0040, 32'h0000_0040, 32'd0, 12'h040, "stride0");
    one_beat(1, 32'h0000_0100, 32'h0000_0080, 32'd4, 12'h0BE, "base>end");

    // Asynchronous reset with two beats outstanding.
    set_pkt(0, 32'h7000, 32'h7100, 32'd8, 3'd1, 12'h777);
    pkt_valid = 2'b01;
    step;
    pkt_valid = 2'b00;
    step;
    step;
    chk("ar pre addr", 64'(req_addr), 64'h7008);
    #2 rst_n = 1'b0;
    #1;
    chk("ar valid", 64'(req_valid), 64'd0);
    chk("ar addr", 64'(req_addr), 64'd0);
    chk("ar id", 64'(req_id), 64'd0);
    chk("ar last", 64'(req_last), 64'd0);
    chk("ar size", 64'(req_size), 64'd0);
    chk("ar ready", 64'(pkt_ready), 64'd3);
    chk("ar done", 64'(done_valid), 64'd0);
    #3 rst_n = 1'b1;
    step;
    set_pkt(0, 32'h7800, 32'h7808, 32'd8, 3'd1, 12'h456);
    pkt_valid = 2'b01;
    step;
    pkt_valid = 2'b00;
    chk("ar2 latency", 64'(req_valid), 64'd0);
    step;
    chk("ar2 b0 addr", 64'(req_addr), 64'h7800);
    chk("ar2 b0 last", 64'(req_last), 64'd0);
    step;
    chk("ar2 b1 addr", 64'(req_addr), 64'h7808);
    chk("ar2 b1 last", 64'(req_last), 64'd1);
    step;
    chk("ar2 drained", 64'(req_valid), 64'd0);
    rsp_valid = 2'b01;
    step;
    chk("ar2 early done", 64'(done_valid), 64'd0);
    step;
    rsp_valid = 2'b00;
    chk("ar2 done", 64'(done_valid), 64'd1);
    chk("ar2 done_id", 64'(done_id), 64'h456);
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
